// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for an RV32I-subset datapath: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes, counts retirements, traps on error.
module mc_ctrl_fsm #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic [CNT_W-1:0] instret,
  output logic             trap
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;

  // The ALU has no unsigned compare, so funct3=011 is illegal; funct7b5 is only
  // meaningful for SUB/SRA (R) and SRAI (I), and SLLI with it set is illegal.
  logic r_ok, i_ok, is_r, is_i, is_lw, is_sw, is_br, is_jal, legal, taken;

  always_comb begin
    r_ok   = (funct3 != 3'b011) && (!funct7b5 || funct3 == 3'b000 || funct3 == 3'b101);
    i_ok   = (funct3 != 3'b011) && !(funct3 == 3'b001 && funct7b5);
    is_r   = (opcode == OP_R) && r_ok;
    is_i   = (opcode == OP_I) && i_ok;
    is_lw  = (opcode == OP_LOAD)  && (funct3 == 3'b010);
    is_sw  = (opcode == OP_STORE) && (funct3 == 3'b010);
    is_br  = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b00);
    is_jal = (opcode == OP_JAL);
    legal  = is_r || is_i || is_lw || is_sw || is_br || is_jal;
    taken  = funct3[0] ? !zero : zero;
  end

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic b5, input logic allow_sub);
    case (f3)
      3'b000:  alu_op = (allow_sub && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  endfunction

  // NOTE: every output and next-state variable gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    wait_nxt  = 8'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    alu_src_b = 1'b0;
    alu_ctrl  = ALU_ADD;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          state_nxt = S_DECODE;
        end else if (wait_cnt == WAIT_MAX) begin
          state_nxt = S_TRAP;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_DECODE: state_nxt = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        alu_src_b = 1'b1;
        if (is_r) begin
          alu_src_b = 1'b0;
          alu_ctrl  = alu_op(funct3, funct7b5, 1'b1);
          state_nxt = S_WB;
        end else if (is_i) begin
          alu_ctrl  = alu_op(funct3, funct7b5, 1'b0);
          state_nxt = S_WB;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else if (is_jal) begin
          state_nxt = S_WB;
        end else if (is_br) begin
          alu_src_b = 1'b0;
          alu_ctrl  = ALU_SUB;
          pc_write  = 1'b1;
          pc_src    = taken;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_TRAP;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            pc_write  = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (wait_cnt == WAIT_MAX) begin
          state_nxt = S_TRAP;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_lw ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
        pc_write  = 1'b1;
        pc_src    = is_jal;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_TRAP;
    endcase

    // Strobes must be quiet the moment reset asserts, even mid-access.
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'b00;
      alu_src_b = 1'b0;
      alu_ctrl  = ALU_ADD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
      instret  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (pc_write) instret <= instret + CNT_W'(1);
    end
  end

  assign trap = (state == S_TRAP);

endmodule
